// File: rtl/gpio_key_tx.sv
// gpio_key_tx: 4-deep FIFO feeding an 8-bit parallel strobe link (setup, strobe, hold, gap per byte)
module gpio_key_tx #(
  parameter int SETUP_CYCLES  = 50,
  parameter int STROBE_CYCLES = 6000,
  parameter int HOLD_CYCLES   = 100,
  parameter int GAP_CYCLES    = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [7:0] o_link_data,
  output logic       o_link_strobe,
  output logic       o_busy,
  output logic [2:0] o_fifo_count
);
  localparam int MAX_SH = SETUP_CYCLES > HOLD_CYCLES ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_SG = STROBE_CYCLES > GAP_CYCLES ? STROBE_CYCLES : GAP_CYCLES;
  localparam int MAXP   = MAX_SH > MAX_SG ? MAX_SH : MAX_SG;
  localparam int CW     = MAXP > 1 ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] L_SETUP  = CW'(SETUP_CYCLES  > 0 ? SETUP_CYCLES  - 1 : 0);
  localparam logic [CW-1:0] L_STROBE = CW'(STROBE_CYCLES > 0 ? STROBE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] L_HOLD   = CW'(HOLD_CYCLES   > 0 ? HOLD_CYCLES   - 1 : 0);
  localparam logic [CW-1:0] L_GAP    = CW'(GAP_CYCLES    > 0 ? GAP_CYCLES    - 1 : 0);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_mem [4];
  logic [1:0]    r_wp, r_rp;
  logic [2:0]    r_count;
  logic [7:0]    r_data, r_link_data;
  logic          r_link_strobe, r_busy, w_push, w_pop;
  assign o_in_ready    = r_count != 3'd4;
  assign w_push        = i_in_valid && o_in_ready;
  assign o_link_data   = r_link_data;
  assign o_link_strobe = r_link_strobe;
  assign o_busy        = r_busy;
  assign o_fifo_count  = r_count;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt == '0 ? '0 : r_cnt - 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: if (r_count != 3'd0) begin
        w_pop       = 1'b1;
        w_state_nxt = SETUP_CYCLES > 0 ? S_SETUP : S_STROBE;
        w_cnt_nxt   = SETUP_CYCLES > 0 ? L_SETUP : L_STROBE;
      end
      S_SETUP: if (r_cnt == '0) begin
        w_state_nxt = S_STROBE;
        w_cnt_nxt   = L_STROBE;
      end
      S_STROBE: if (r_cnt == '0) begin
        w_state_nxt = HOLD_CYCLES > 0 ? S_HOLD : (GAP_CYCLES > 0 ? S_GAP : S_IDLE);
        w_cnt_nxt   = HOLD_CYCLES > 0 ? L_HOLD : L_GAP;
      end
      S_HOLD: if (r_cnt == '0) begin
        w_state_nxt = GAP_CYCLES > 0 ? S_GAP : S_IDLE;
        w_cnt_nxt   = L_GAP;
      end
      S_GAP: if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_in_data;
  end
  // Link outputs are a registered image of the current state, so they trail the FSM by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_wp          <= '0;
      r_rp          <= '0;
      r_count       <= '0;
      r_data        <= '0;
      r_link_data   <= '0;
      r_link_strobe <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wp          <= r_wp + {1'b0, w_push};
      r_rp          <= r_rp + {1'b0, w_pop};
      r_count       <= r_count + {2'b0, w_push} - {2'b0, w_pop};
      r_data        <= w_pop ? r_mem[r_rp] : r_data;
      r_link_data   <= (r_state == S_SETUP || r_state == S_STROBE || r_state == S_HOLD) ? r_data : 8'h00;
      r_link_strobe <= r_state == S_STROBE;
      r_busy        <= r_count != 3'd0 || r_state != S_IDLE;
    end
  end
endmodule

// File: tb/tb_gpio_key_tx.sv
// tb_gpio_key_tx: directed checks of gpio_key_tx with 2/5/3/2 and 0/1/0/0 timing
module tb_gpio_key_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] a_din = '0, b_din = '0;
  logic a_vld = 1'b0, b_vld = 1'b0;
  logic a_rdy, a_stb, a_busy, b_rdy, b_stb, b_busy;
  logic [7:0] a_ld, b_ld;
  logic [2:0] a_cnt, b_cnt;
  int tests = 0, fails = 0;
  logic [7:0] q_b [5];
  int q_t [5];
  int q_n;
  always #5 clk = ~clk;
  gpio_key_tx #(.SETUP_CYCLES(2), .STROBE_CYCLES(5), .HOLD_CYCLES(3), .GAP_CYCLES(2)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(a_din), .i_in_valid(a_vld), .o_in_ready(a_rdy),
    .o_link_data(a_ld), .o_link_strobe(a_stb), .o_busy(a_busy), .o_fifo_count(a_cnt));
  gpio_key_tx #(.SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0), .GAP_CYCLES(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(b_din), .i_in_valid(b_vld), .o_in_ready(b_rdy),
    .o_link_data(b_ld), .o_link_strobe(b_stb), .o_busy(b_busy), .o_fifo_count(b_cnt));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Pushes q_b[j] on edge q_t[j]; with the FIFO never running dry, byte k is popped at edge 1+13k,
  // is on the link after edges 2+13k..11+13k and strobes after edges 4+13k..8+13k.
  task automatic run_a(input int endc, input int chk_c, input int exp_cnt);
    int k, r;
    for (int c = 0; c <= endc; c++) begin
      a_vld = 1'b0;
      for (int j = 0; j < q_n; j++) if (q_t[j] == c) begin a_vld = 1'b1; a_din = q_b[j]; end
      tick();
      a_vld = 1'b0;
      k = c / 13;
      r = c % 13;
      chk($sformatf("a_data c=%0d", c), a_ld, (k < q_n && r >= 2 && r <= 11) ? q_b[k] : 8'h00);
      chk($sformatf("a_strobe c=%0d", c), a_stb, k < q_n && r >= 4 && r <= 8);
      if (c == chk_c) begin
        chk("a_fifo_count", a_cnt, exp_cnt);
        chk("a_in_ready", a_rdy, exp_cnt != 4);
      end
    end
    chk("a_busy_end", a_busy, 0);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_data", a_ld, 8'h00);
    chk("rst_strobe", a_stb, 0);
    chk("rst_ready", a_rdy, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_count", a_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_data", a_ld, 8'h00);
    chk("post_rst_ready", a_rdy, 1);
    chk("post_rst_count", a_cnt, 0);
    // single byte: pop at edge 1, busy still high at 13, low at 14
    q_n = 1; q_b[0] = 8'hFC; q_t[0] = 0;
    run_a(14, 1, 0);
    // burst of five: FIFO full after edge 4 with byte 1 already on the link
    q_n = 5;
    for (int j = 0; j < 5; j++) begin q_b[j] = 8'(j + 1); q_t[j] = j; end
    run_a(66, 4, 4);
    // push on the edge that pops byte B from a two-deep FIFO (edge 14)
    q_n = 4;
    q_b[0] = 8'h11; q_b[1] = 8'h22; q_b[2] = 8'h33; q_b[3] = 8'h44;
    q_t[0] = 0; q_t[1] = 1; q_t[2] = 2; q_t[3] = 14;
    run_a(53, 14, 2);
    // reset during strobe with two bytes queued
    a_vld = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      a_din = 8'hC0 + 8'(c);
      a_vld = c < 3;
      tick();
    end
    a_vld = 1'b0;
    chk("pre_rst_strobe", a_stb, 1);
    chk("pre_rst_count", a_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_strobe", a_stb, 0);
    chk("async_rst_data", a_ld, 8'h00);
    chk("async_rst_count", a_cnt, 0);
    chk("async_rst_busy", a_busy, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk($sformatf("after_rst_strobe c=%0d", c), a_stb, 0);
      chk($sformatf("after_rst_data c=%0d", c), a_ld, 8'h00);
    end
    chk("after_rst_busy", a_busy, 0);
    // 0/1/0/0: byte k popped at edge 1+2k, strobed with data after edge 2+2k
    for (int c = 0; c <= 6; c++) begin
      b_vld = c < 2;
      b_din = c == 0 ? 8'hA5 : 8'h5A;
      tick();
      b_vld = 1'b0;
      chk($sformatf("b_data c=%0d", c), b_ld, c == 2 ? 8'hA5 : c == 4 ? 8'h5A : 8'h00);
      chk($sformatf("b_strobe c=%0d", c), b_stb, c == 2 || c == 4);
      if (c == 1) chk("b_count_pushpop", b_cnt, 1);
    end
    chk("b_busy_end", b_busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpio_key_tx.md
# gpio_key_tx

Transmitter side of the 8-bit parallel strobe link that the game board samples on gpio1: data on pins 35,21,33,23,31,25,39,27 (MSB→LSB), strobe on pin 37. The block accepts bytes over a valid/ready interface and buffers them in a 4-entry FIFO. Each byte is driven onto the link as setup → strobe-high → hold → gap. It is used on the controller/test-harness board and in system simulation to replace hand-timed gpio stimulus.

## Interface
- SETUP_CYCLES, default 50: cycles data is stable before strobe rises (1 µs at 50 MHz).
- STROBE_CYCLES, default 6000: cycles strobe is held high (120 µs); must be ≥1.
- HOLD_CYCLES, default 100: cycles data is held after strobe falls.
- GAP_CYCLES, default 50: idle cycles (data 0, strobe 0) before the next byte may start.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is offered this cycle.
- in_ready  output  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- link_data  output  8  to gpio1 {35,21,33,23,31,25,39,27}, bit 7 first in that list.
- link_strobe  output  1  to gpio1[37].
- busy  output  1  high whenever the FIFO is non-empty or the FSM is not IDLE.
- fifo_count  output  3  number of queued bytes, 0..4.

## Operation
- FIFO: 4 entries, circular, 2-bit read and write pointers plus a 3-bit count.
  - in_ready = (count != 4).
  - A push and a pop in the same cycle leave count unchanged. A push while full is impossible because in_ready is low.
  - A push into an empty FIFO pops no earlier than the next cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP. A single down-counter, sized to the largest parameter, times every state.
- IDLE: outputs link_data=0, link_strobe=0. If the FIFO is non-empty: pop the head into the data register, load SETUP_CYCLES-1, go to SETUP. If SETUP_CYCLES=0, skip SETUP and go straight to STROBE.
- SETUP: link_data = data register, strobe low. Counter at 0 → load STROBE_CYCLES-1, go to STROBE.
- STROBE: link_data = data register, strobe high. Counter at 0 → go to HOLD (or GAP if HOLD_CYCLES=0).
- HOLD: link_data = data register, strobe low. Counter at 0 → go to GAP (or IDLE if GAP_CYCLES=0).
- GAP: link_data=0, strobe low. Counter at 0 → IDLE.
- link_data only changes in the cycle the FSM enters SETUP or enters GAP, never while strobe is high.
- Bytes are sent strictly in FIFO order. None are dropped or duplicated.
- All outputs are registered, with no combinational path from in_* to link_*. in_ready is combinational from count only.

## Timing
- Reset (rst low, asynchronous): FSM=IDLE, counter=0, pointers=0, count=0, link_data=0x00, link_strobe=0, busy=0, in_ready=1. Takes effect immediately, including mid-strobe: strobe drops without waiting for a clock. All queued bytes are discarded.
- Latency: a byte accepted at edge N into an empty, idle block is popped at edge N+1. link_data is valid after edge N+2, and link_strobe rises SETUP_CYCLES cycles after that.
- Strobe high width: exactly STROBE_CYCLES clocks.
- Per-byte period: SETUP+STROBE+HOLD+GAP cycles plus 1 IDLE cycle.
- busy falls in the first IDLE cycle with the FIFO empty.
- Acceptance of in_data continues during every FSM state.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release → link_data=0x00, link_strobe=0, in_ready=1, busy=0, fifo_count=0.
- Single byte, params 2/5/3/2: push 0xFC → link_data=0xFC two edges later. Strobe high exactly 5 cycles, starting 2 cycles after data. Data stays 0xFC 3 cycles after strobe falls, then 0x00. busy low after 14 cycles.
- Burst and backpressure: push 0x01..0x05 back-to-back → in_ready low after the 4th is queued behind the active byte. Link shows 0x01,0x02,0x03,0x04,0x05 in order with identical timing per byte.
- Simultaneous push/pop: push on the same edge the FSM pops from a count=2 FIFO → fifo_count stays 2 and no byte is lost.
- Reset mid-strobe: assert rst during STROBE with 2 bytes queued → strobe drops asynchronously. After release the FIFO is empty and nothing is retransmitted.
- Zero-length SETUP/HOLD/GAP params (0/1/0/0): push 0xA5, 0x5A → each strobe is 1 cycle wide with data stable on that cycle. Bytes are separated only by the IDLE cycle.
